mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory handshake.
// Every output is registered; a per-transaction timeout turns a stalled memory into an error completion.
module mem_arbiter #(
    parameter  int WIDTH      = 16,
    parameter  int DEPTH      = 64,
    parameter  int TIMEOUT    = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  req0_valid_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [WIDTH-1:0]      req0_wdata_i,
    input  logic                  req0_wr_rd_i,
    output logic                  req0_ready_o,
    output logic [WIDTH-1:0]      req0_rdata_o,
    output logic                  req0_err_o,
    input  logic                  req1_valid_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [WIDTH-1:0]      req1_wdata_i,
    input  logic                  req1_wr_rd_i,
    output logic                  req1_ready_o,
    output logic [WIDTH-1:0]      req1_rdata_o,
    output logic                  req1_err_o,
    output logic                  mem_valid_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    output logic                  mem_wr_rd_o,
    input  logic                  mem_ready_i,
    input  logic [WIDTH-1:0]      mem_rdata_i,
    output logic [1:0]            grant_o
);
    // state   | meaning
    // S_IDLE  | waiting for a request; arbitrates and latches the winner
    // S_ISSUE | mem_valid_o held high until mem_ready_i or timeout
    // S_RESP  | one-cycle completion pulse, pointer update, back to idle
    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_mem_valid, w_mem_valid;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
    logic [WIDTH-1:0]      r_mem_wdata, w_mem_wdata;
    logic                  r_mem_wr_rd, w_mem_wr_rd;
    logic [1:0]            r_grant, w_grant;
    logic [1:0]            r_ready, w_ready;
    logic [1:0]            r_err, w_err;
    logic [WIDTH-1:0]      r_rdata0, w_rdata0;
    logic [WIDTH-1:0]      r_rdata1, w_rdata1;
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt;
    logic                  r_prio1, w_prio1;

    logic                  w_any;
    logic                  w_sel1;
    logic                  w_timeout;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;

    assign w_any     = req0_valid_i | req1_valid_i;
    // req1 wins when alone, or on a tie when the pointer favours it
    assign w_sel1    = req1_valid_i & (~req0_valid_i | r_prio1);
    assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);
    assign w_timeout = ~mem_ready_i & (w_cnt_inc == CNT_WIDTH'(TIMEOUT));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE: if (mem_ready_i || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_valid = r_mem_valid;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_mem_wr_rd = r_mem_wr_rd;
        w_grant     = r_grant;
        w_ready     = 2'b00;
        w_err       = 2'b00;
        w_rdata0    = r_rdata0;
        w_rdata1    = r_rdata1;
        w_cnt       = r_cnt;
        w_prio1     = r_prio1;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_mem_valid = 1'b1;
                    w_grant     = w_sel1 ? 2'b10 : 2'b01;
                    w_mem_addr  = w_sel1 ? req1_addr_i  : req0_addr_i;
                    w_mem_wdata = w_sel1 ? req1_wdata_i : req0_wdata_i;
                    w_mem_wr_rd = w_sel1 ? req1_wr_rd_i : req0_wr_rd_i;
                    w_cnt       = '0;
                end
            end
            S_ISSUE: begin
                if (mem_ready_i) begin
                    w_mem_valid = 1'b0;
                    w_ready     = r_grant;
                    if (!r_mem_wr_rd) begin
                        if (r_grant[1]) w_rdata1 = mem_rdata_i;
                        else            w_rdata0 = mem_rdata_i;
                    end
                end else begin
                    w_cnt = w_cnt_inc;
                    if (w_timeout) begin
                        w_mem_valid = 1'b0;
                        w_ready     = r_grant;
                        w_err       = r_grant;
                    end
                end
            end
            S_RESP: begin
                w_grant = 2'b00;
                w_cnt   = '0;
                w_prio1 = r_grant[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wr_rd <= 1'b0;
            r_grant     <= 2'b00;
            r_ready     <= 2'b00;
            r_err       <= 2'b00;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_cnt       <= '0;
            r_prio1     <= 1'b0;
        end else begin
            r_mem_valid <= w_mem_valid;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_mem_wr_rd <= w_mem_wr_rd;
            r_grant     <= w_grant;
            r_ready     <= w_ready;
            r_err       <= w_err;
            r_rdata0    <= w_rdata0;
            r_rdata1    <= w_rdata1;
            r_cnt       <= w_cnt;
            r_prio1     <= w_prio1;
        end
    end

    assign mem_valid_o  = r_mem_valid;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wdata_o  = r_mem_wdata;
    assign mem_wr_rd_o  = r_mem_wr_rd;
    assign grant_o      = r_grant;
    assign req0_ready_o = r_ready[0];
    assign req1_ready_o = r_ready[1];
    assign req0_err_o   = r_err[0];
    assign req1_err_o   = r_err[1];
    assign req0_rdata_o = r_rdata0;
    assign req1_rdata_o = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus timeout, reset and contention sequences.
module tb_mem_arbiter;
    logic        clk_i;
    logic        reset_ni;
    logic        req0_valid_i, req1_valid_i;
    logic [5:0]  req0_addr_i, req1_addr_i;
    logic [15:0] req0_wdata_i, req1_wdata_i;
    logic        req0_wr_rd_i, req1_wr_rd_i;
    logic        req0_ready_o, req1_ready_o;
    logic [15:0] req0_rdata_o, req1_rdata_o;
    logic        req0_err_o, req1_err_o;
    logic        mem_valid_o;
    logic [5:0]  mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic        mem_wr_rd_o;
    logic        mem_ready_i;
    logic [15:0] mem_rdata_i;
    logic [1:0]  grant_o;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.WIDTH(16), .DEPTH(64), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
        .req0_wr_rd_i(req0_wr_rd_i), .req0_ready_o(req0_ready_o), .req0_rdata_o(req0_rdata_o),
        .req0_err_o(req0_err_o),
        .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
        .req1_wr_rd_i(req1_wr_rd_i), .req1_ready_o(req1_ready_o), .req1_rdata_o(req1_rdata_o),
        .req1_err_o(req1_err_o),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wr_rd_o(mem_wr_rd_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .grant_o(grant_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic v0, v1, w0, w1;
        logic [5:0] a0, a1;
        logic [15:0] d0, d1;
        logic mr;
        logic [15:0] md;
        logic mv;
        logic [1:0] gnt, rdy, err;
        logic wr;
        logic [5:0] addr;
        logic [15:0] wd, rd0, rd1;
    } vec_t;

    vec_t vt [21];

    function automatic logic [63:0] ctrl_now();
        return 64'({mem_valid_o, grant_o, req1_ready_o, req0_ready_o, req1_err_o, req0_err_o});
    endfunction

    function automatic logic [63:0] data_now();
        return 64'({mem_wr_rd_o, mem_addr_o, mem_wdata_o, req0_rdata_o, req1_rdata_o});
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n_issue;
        int k;
        logic [1:0] exp_gnt [4];
        logic [1:0] prev_rdy;

        reset_ni = 1'b0;
        req0_valid_i = 0; req1_valid_i = 0; req0_wr_rd_i = 0; req1_wr_rd_i = 0;
        req0_addr_i = '0; req1_addr_i = '0; req0_wdata_i = '0; req1_wdata_i = '0;
        mem_ready_i = 0; mem_rdata_i = '0;

        //        v0    v1    w0    w1    a0     a1     d0        d1        mr    md          mv    gnt    rdy    err    wr    addr   wd        rd0       rd1
        vt[0]  = '{1'b1,1'b0,1'b1,1'b0,6'd5,6'd0,16'hA5A5,16'h0000,1'b0,16'h0000, 1'b1,2'b01,2'b00,2'b00,1'b1,6'd5,16'hA5A5,16'h0000,16'h0000};
        vt[1]  = vt[0];
        vt[2]  = '{1'b1,1'b0,1'b1,1'b0,6'd5,6'd0,16'hA5A5,16'h0000,1'b1,16'h1234, 1'b0,2'b01,2'b01,2'b00,1'b1,6'd5,16'hA5A5,16'h0000,16'h0000};
        vt[3]  = '{1'b1,1'b0,1'b1,1'b0,6'd5,6'd0,16'hA5A5,16'h0000,1'b0,16'h0000, 1'b0,2'b00,2'b00,2'b00,1'b1,6'd5,16'hA5A5,16'h0000,16'h0000};
        vt[4]  = '{1'b0,1'b0,1'b1,1'b0,6'd5,6'd0,16'hA5A5,16'h0000,1'b1,16'hBEEF, 1'b0,2'b00,2'b00,2'b00,1'b1,6'd5,16'hA5A5,16'h0000,16'h0000};
        vt[5]  = '{1'b0,1'b1,1'b0,1'b0,6'd0,6'd5,16'h0000,16'h0000,1'b0,16'h0000, 1'b1,2'b10,2'b00,2'b00,1'b0,6'd5,16'h0000,16'h0000,16'h0000};
        vt[6]  = vt[5];
        vt[7]  = '{1'b0,1'b1,1'b0,1'b0,6'd0,6'd5,16'h0000,16'h0000,1'b1,16'hA5A5, 1'b0,2'b10,2'b10,2'b00,1'b0,6'd5,16'h0000,16'h0000,16'hA5A5};
        vt[8]  = '{1'b0,1'b1,1'b0,1'b0,6'd0,6'd5,16'h0000,16'h0000,1'b1,16'hFFFF, 1'b0,2'b00,2'b00,2'b00,1'b0,6'd5,16'h0000,16'h0000,16'hA5A5};
        vt[9]  = '{1'b0,1'b1,1'b0,1'b0,6'd0,6'd3,16'h0000,16'h0000,1'b0,16'h0000, 1'b1,2'b10,2'b00,2'b00,1'b0,6'd3,16'h0000,16'h0000,16'hA5A5};
        vt[10] = vt[9];
        vt[11] = '{1'b0,1'b1,1'b0,1'b0,6'd0,6'd3,16'h0000,16'h0000,1'b1,16'h0F0F, 1'b0,2'b10,2'b10,2'b00,1'b0,6'd3,16'h0000,16'h0000,16'h0F0F};
        vt[12] = '{1'b0,1'b1,1'b0,1'b0,6'd0,6'd3,16'h0000,16'h0000,1'b0,16'h0000, 1'b0,2'b00,2'b00,2'b00,1'b0,6'd3,16'h0000,16'h0000,16'h0F0F};
        vt[13] = '{1'b1,1'b1,1'b1,1'b0,6'd7,6'd9,16'h1111,16'h2222,1'b0,16'h0000, 1'b1,2'b01,2'b00,2'b00,1'b1,6'd7,16'h1111,16'h0000,16'h0F0F};
        vt[14] = vt[13];
        vt[15] = '{1'b1,1'b1,1'b1,1'b0,6'd7,6'd9,16'h1111,16'h2222,1'b1,16'h3333, 1'b0,2'b01,2'b01,2'b00,1'b1,6'd7,16'h1111,16'h0000,16'h0F0F};
        vt[16] = '{1'b1,1'b1,1'b1,1'b0,6'd7,6'd9,16'h1111,16'h2222,1'b0,16'h0000, 1'b0,2'b00,2'b00,2'b00,1'b1,6'd7,16'h1111,16'h0000,16'h0F0F};
        vt[17] = '{1'b1,1'b1,1'b1,1'b0,6'd7,6'd9,16'h1111,16'h2222,1'b0,16'h0000, 1'b1,2'b10,2'b00,2'b00,1'b0,6'd9,16'h2222,16'h0000,16'h0F0F};
        vt[18] = vt[17];
        vt[19] = '{1'b1,1'b1,1'b1,1'b0,6'd7,6'd9,16'h1111,16'h2222,1'b1,16'h4444, 1'b0,2'b10,2'b10,2'b00,1'b0,6'd9,16'h2222,16'h0000,16'h4444};
        vt[20] = '{1'b1,1'b1,1'b1,1'b0,6'd7,6'd9,16'h1111,16'h2222,1'b0,16'h0000, 1'b0,2'b00,2'b00,2'b00,1'b0,6'd9,16'h2222,16'h0000,16'h4444};

        #23;
        check("reset_ctrl", ctrl_now(), 64'd0);
        check("reset_data", data_now(), 64'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;

        for (int i = 0; i < 21; i++) begin
            req0_valid_i = vt[i].v0; req1_valid_i = vt[i].v1;
            req0_wr_rd_i = vt[i].w0; req1_wr_rd_i = vt[i].w1;
            req0_addr_i  = vt[i].a0; req1_addr_i  = vt[i].a1;
            req0_wdata_i = vt[i].d0; req1_wdata_i = vt[i].d1;
            mem_ready_i  = vt[i].mr; mem_rdata_i  = vt[i].md;
            tick();
            check($sformatf("vec%0d_ctrl", i), ctrl_now(),
                  64'({vt[i].mv, vt[i].gnt, vt[i].rdy, vt[i].err}));
            check($sformatf("vec%0d_data", i), data_now(),
                  64'({vt[i].wr, vt[i].addr, vt[i].wd, vt[i].rd0, vt[i].rd1}));
        end

        // timeout: req0 read with the memory never answering
        req1_valid_i = 0;
        req0_valid_i = 1; req0_wr_rd_i = 0; req0_addr_i = 6'd1; req0_wdata_i = '0;
        mem_ready_i = 0; mem_rdata_i = 16'hDEAD;
        tick();
        check("to_issue", ctrl_now(), 64'({1'b1, 2'b01, 2'b00, 2'b00}));
        n_issue = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (!mem_valid_o) break;
            n_issue++;
        end
        check("to_issue_cycles", 64'(n_issue), 64'd16);
        check("to_resp", ctrl_now(), 64'({1'b0, 2'b01, 2'b01, 2'b01}));
        check("to_rdata_hold", 64'(req0_rdata_o), 64'h0000);
        tick();
        check("to_pulse_end", ctrl_now(), 64'd0);
        tick();
        tick();
        mem_ready_i = 1; mem_rdata_i = 16'h5A5A;
        tick();
        check("after_to_ctrl", ctrl_now(), 64'({1'b0, 2'b01, 2'b01, 2'b00}));
        check("after_to_rdata", 64'(req0_rdata_o), 64'h5A5A);
        mem_ready_i = 0; req0_valid_i = 0;
        tick();

        // reset while req1 is in ISSUE; req0 and req1 tie afterwards
        req1_valid_i = 1; req1_wr_rd_i = 0; req1_addr_i = 6'd2;
        tick();
        check("rst_pre_issue", ctrl_now(), 64'({1'b1, 2'b10, 2'b00, 2'b00}));
        #2;
        reset_ni = 1'b0;
        #1;
        check("rst_async_ctrl", ctrl_now(), 64'd0);
        check("rst_async_data", data_now(), 64'd0);
        req0_valid_i = 1; req0_wr_rd_i = 1; req0_addr_i = 6'd4; req0_wdata_i = 16'h7777;
        tick();
        check("rst_held_ctrl", ctrl_now(), 64'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        tick();
        check("rst_tie_grant", ctrl_now(), 64'({1'b1, 2'b01, 2'b00, 2'b00}));
        check("rst_tie_data", 64'({mem_wr_rd_o, mem_addr_o, mem_wdata_o}), 64'({1'b1, 6'd4, 16'h7777}));
        tick();
        mem_ready_i = 1;
        tick();
        check("rst_done", ctrl_now(), 64'({1'b0, 2'b01, 2'b01, 2'b00}));

        // continuous contention with mem_ready_i held high
        exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
        k = 0;
        prev_rdy = {req1_ready_o, req0_ready_o};
        for (int c = 0; c < 40 && k < 4; c++) begin
            tick();
            if (req0_ready_o || req1_ready_o) begin
                check($sformatf("cont_grant%0d", k), 64'(grant_o), 64'(exp_gnt[k]));
                check($sformatf("cont_ready%0d", k), 64'({prev_rdy, req1_ready_o, req0_ready_o}),
                      64'({2'b00, exp_gnt[k]}));
                k++;
            end
            prev_rdy = {req1_ready_o, req0_ready_o};
        end
        check("cont_completions", 64'(k), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
